// File: rtl/fifo_umbral_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_umbral_pkg
// Description : Shared threshold-word layout and reset defaults for fifo_umbral.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_umbral_pkg;

    localparam int UMBRALES_L_H    = 8;

    localparam int UMBRAL_ALTO_MSB = 7;
    localparam int UMBRAL_ALTO_LSB = 4;
    localparam int UMBRAL_BAJO_MSB = 3;
    localparam int UMBRAL_BAJO_LSB = 0;

    localparam int UMBRAL_W        = UMBRAL_ALTO_MSB - UMBRAL_ALTO_LSB + 1;

    localparam logic [UMBRAL_W-1:0] UMBRAL_BAJO_RST = 4'd1;
    localparam logic [UMBRAL_W-1:0] UMBRAL_ALTO_RST = 4'd6;

endpackage
`default_nettype wire

// File: rtl/fifo_umbral_memoria.sv
`default_nettype none
// ============================================================================
// Module      : memoria_fifo
// Description : DEPTH x DATA_WIDTH register array, synchronous write and
//               registered read port that holds its value when not read.
// Revision    : 1.0 - initial release
// ============================================================================
module memoria_fifo #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Storage is intentionally left uninitialised by reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read-before-write: a same-edge read of the slot being written returns the old word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/fifo_umbral.sv
`default_nettype none
// ============================================================================
// Module      : fifo_umbral
// Description : Single-clock FIFO with programmable almost-empty/almost-full
//               thresholds and a sticky overflow/underflow error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_umbral #(
    parameter int DATA_WIDTH   = 6,
    parameter int ADDR_WIDTH   = 3,
    parameter int UMBRALES_L_H = fifo_umbral_pkg::UMBRALES_L_H
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [UMBRALES_L_H-1:0] umbral_LH,
    input  logic                    umbral_load,
    input  logic                    push,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    pop,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    valid_out,
    output logic                    empty_fifo,
    output logic                    full_fifo,
    output logic                    almost_empty,
    output logic                    almost_full,
    output logic                    error_fifo
);

    import fifo_umbral_pkg::*;

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam int CMP_W = (CNT_W > UMBRAL_W) ? CNT_W : UMBRAL_W;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  valid_q, valid_d;
    logic                  error_q, error_d;
    logic [UMBRAL_W-1:0]   alto_q, alto_d;
    logic [UMBRAL_W-1:0]   bajo_q, bajo_d;

    logic w_pop_ok;
    logic w_push_ok;
    logic [CMP_W-1:0] w_count_ext;
    logic [CMP_W-1:0] w_alto_ext;
    logic [CMP_W-1:0] w_bajo_ext;

    // A full FIFO still accepts a push when a pop frees the slot on the same edge.
    assign w_pop_ok  = reset && pop && (count_q != '0);
    assign w_push_ok = reset && push && ((count_q != DEPTH_C) || w_pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = w_pop_ok;
        error_d  = error_q;
        alto_d   = alto_q;
        bajo_d   = bajo_q;

        if (w_push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({w_push_ok, w_pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if ((push && !w_push_ok) || (pop && !w_pop_ok)) begin
            error_d = 1'b1;
        end

        if (umbral_load) begin
            alto_d = umbral_LH[UMBRAL_ALTO_MSB:UMBRAL_ALTO_LSB];
            bajo_d = umbral_LH[UMBRAL_BAJO_MSB:UMBRAL_BAJO_LSB];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
            alto_q   <= UMBRAL_ALTO_RST;
            bajo_q   <= UMBRAL_BAJO_RST;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
            alto_q   <= alto_d;
            bajo_q   <= bajo_d;
        end
    end

    memoria_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_memoria (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (w_push_ok),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (data_in),
        .rd_en_i   (w_pop_ok),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (data_out)
    );

    // Zero-extend both sides so out-of-range thresholds compare naturally.
    assign w_count_ext = CMP_W'(count_q);
    assign w_alto_ext  = CMP_W'(alto_q);
    assign w_bajo_ext  = CMP_W'(bajo_q);

    assign valid_out    = valid_q;
    assign error_fifo   = error_q;
    assign empty_fifo   = (count_q == '0);
    assign full_fifo    = (count_q == DEPTH_C);
    assign almost_empty = (w_count_ext <= w_bajo_ext);
    assign almost_full  = (w_count_ext >= w_alto_ext);

endmodule
`default_nettype wire

// File: doc/fifo_umbral.md
Name: fifo_umbral

Overview:
- Single-clock synchronous FIFO. The low-level/high-level threshold word (umbral_LH) produced by the fsm block is the FIFO's configuration input.
- Returns the empty_fifo status that the fsm block samples in its idle/active decision.
- Eight instances sit between the routing logic and the fsm block, one per empty_fifo_N line.
- Provides programmable almost-empty/almost-full flags derived from the loaded thresholds, plus a sticky error flag.

Parameters:
- DATA_WIDTH, 6: width of each stored word.
- ADDR_WIDTH, 3: pointer width; DEPTH = 2**ADDR_WIDTH = 8 entries.
- UMBRALES_L_H, 8: threshold word width; upper half = high threshold, lower half = low threshold.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-low reset; sampled only at posedge clk.
- umbral_LH  input  UMBRALES_L_H  threshold word: [7:4] umbral_alto, [3:0] umbral_bajo.
- umbral_load  input  1  when 1 at posedge, umbral_LH is captured into the threshold registers.
- push  input  1  write request.
- data_in  input  DATA_WIDTH  write data.
- pop  input  1  read request.
- data_out  output  DATA_WIDTH  registered read data.
- valid_out  output  1  data_out holds a word popped on the previous edge.
- empty_fifo  output  1  count == 0.
- full_fifo  output  1  count == DEPTH.
- almost_empty  output  1  count <= umbral_bajo.
- almost_full  output  1  count >= umbral_alto.
- error_fifo  output  1  sticky overflow/underflow indicator.

Behaviour:
- Reset (reset==0 at posedge): wr_ptr=0, rd_ptr=0, count=0, data_out=0, valid_out=0, error_fifo=0, umbral_bajo=1, umbral_alto=DEPTH-2 (6).
  - Resulting flags: empty_fifo=1, full_fifo=0, almost_empty=1, almost_full=0.
  - Reset overrides every other input that cycle; storage contents are not cleared.
- count is ADDR_WIDTH+1 bits, range 0..DEPTH. Pointers are ADDR_WIDTH bits and wrap naturally from DEPTH-1 to 0.
- Push accepted iff push=1 and (count<DEPTH or a pop is accepted the same cycle). Accepted push writes mem[wr_ptr] and increments wr_ptr.
- Pop accepted iff pop=1 and count>0. Accepted pop:
  - data_out <= mem[rd_ptr], rd_ptr increments, valid_out <= 1 on the same edge.
  - Latency: data is visible one cycle after pop is asserted.
- No accepted pop: valid_out <= 0 and data_out holds its last value.
- Count updates:
  - push only: count+1.
  - pop only: count-1.
  - both: count unchanged.
  - Push and pop on an empty FIFO: push accepted, pop rejected; no bypass of the written word.
  - Push and pop on a full FIFO: both accepted; count stays DEPTH.
- Push while full with no accepted pop: word dropped, error_fifo <= 1.
- Pop while empty: ignored, valid_out <= 0, error_fifo <= 1.
- error_fifo clears only on reset.
- Threshold load: umbral_load=1 captures umbral_alto=umbral_LH[7:4] and umbral_bajo=umbral_LH[3:0] at that edge. Flags use the new values from the next cycle.
  - Load is legal in any cycle, including during push/pop.
- Flags are combinational from the registered count and thresholds; they carry no extra latency beyond count.
- Threshold comparisons are unsigned, 4-bit values zero-extended to count width.
  - umbral_alto > DEPTH means almost_full is never asserted.
  - umbral_alto = 0 means almost_full is always 1.
  - umbral_bajo >= DEPTH means almost_empty is always 1.
  - umbral_bajo < umbral_alto is not enforced; both flags may be 1 at the same time.
- Reset asserted mid-operation discards all queued words. The first post-reset pop reports underflow.

Decomposition:
- Shared package constants:
  - UMBRALES_L_H.
  - Nibble slice positions UMBRAL_ALTO_MSB=7, UMBRAL_ALTO_LSB=4, UMBRAL_BAJO_MSB=3, UMBRAL_BAJO_LSB=0.
  - Reset defaults UMBRAL_BAJO_RST=1, UMBRAL_ALTO_RST=6.
- Natural sub-module: memoria_fifo, a DEPTH x DATA_WIDTH register array with synchronous write and registered read port.
- Pointer, count, flag and threshold logic remain in fifo_umbral.

Test Plan:
- Reset held low 2 cycles, then released -> empty_fifo=1, almost_empty=1, almost_full=0, full_fifo=0, error_fifo=0, valid_out=0.
- Push 0x01..0x08 on 8 consecutive cycles -> after 6th push almost_full=1, after 8th full_fifo=1; empty_fifo falls after 1st push; almost_empty falls after 2nd push.
- Continue with a 9th push (0x09) while full -> word dropped, error_fifo=1 and stays 1. Then 8 pops -> data_out=0x01..0x08 in order, each one cycle after pop, valid_out=1 for 8 cycles.
- umbral_load=1 with umbral_LH=8'b00101110 (alto=2, bajo=14) on an empty FIFO -> next cycle almost_empty=1 at all counts 0..8. After 2 pushes almost_full=1 and almost_empty=1 at the same time.
- Fill to 8, then simultaneous push 0x2A and pop for 3 cycles -> count stays 8, full_fifo=1, error_fifo unchanged, outputs oldest three words, 0x2A is stored at the tail.
- Pop on empty with push=1 in the same cycle -> valid_out=0, error_fifo=1, count=1. Then reset asserted mid-stream with 5 words queued -> count=0, empty_fifo=1, thresholds back to bajo=1/alto=6.
